pad_input_debounce: RTL
=======================

// Module: pad_input_debounce
//
// PURPOSE
//   Conditions asynchronous pad inputs after the input pad and antenna-protection cell.
//   Per channel, the block:
//   - synchronises the pad net into the core clock domain;
//   - filters glitches with a programmable consecutive-sample threshold;
//   - publishes a clean level and one-cycle rise/fall pulses;
//   - raises sticky event flags, cleared by a consumer acknowledge.
//   It sits between the pad ring and core control logic.
//
// PARAMETERS
//   NCH          4   number of independent input channels
//   SYNC_STAGES  2   synchroniser flops per channel (legal range 2..4)
//   CNT_W        8   stability-counter and threshold width, in bits
//
// PORTS
//   Clock        in   1       core clock; all logic on the rising edge
//   nReset       in   1       synchronous reset, active-low
//   PadIn        in   NCH     raw asynchronous pad-side inputs
//   Threshold    in   CNT_W   consecutive stable samples required; 0 is treated as 1
//   Level        out  NCH     debounced level
//   Rise         out  NCH     1-cycle pulse when Level goes 0->1
//   Fall         out  NCH     1-cycle pulse when Level goes 1->0
//   EvtPending   out  NCH     sticky flag: an edge has occurred since the last acknowledge
//   EvtOverrun   out  NCH     sticky flag: an edge occurred while EvtPending was already set
//   EvtAck       in   NCH     per-channel acknowledge; clears both sticky flags
//
// BEHAVIOUR
//   Reset
//   - nReset is sampled at a Clock edge and is active-low.
//   - While nReset is low, every synchroniser flop, counter, Level, Rise, Fall,
//     EvtPending and EvtOverrun is driven to 0, and every FSM is in LO.
//   - A reset asserted mid-check abandons the check; no pulse is emitted.
//   Synchroniser
//   - PadIn[i] passes through SYNC_STAGES flops. The last flop is S[i].
//   Per-channel FSM
//   - States are LO, CHK_HI, HI and CHK_LO. Let N = max(Threshold, 1).
//   - Level is 0 in LO and CHK_HI, and 1 in HI and CHK_LO.
//   - LO:
//     - S=1 and N=1: go to HI and pulse Rise.
//     - S=1 and N>1: go to CHK_HI with cnt=1.
//     - S=0: stay in LO.
//   - CHK_HI:
//     - S=1 and cnt+1>=N: go to HI and pulse Rise.
//     - S=1 otherwise: cnt++.
//     - S=0: go to LO with cnt=0.
//   - HI and CHK_LO mirror LO and CHK_HI with S inverted, and pulse Fall.
//   - Latency: an input that is stable from cycle t has Level change at edge t+SYNC_STAGES+N.
//   - Any glitch shorter than N samples produces no Level change and no pulse.
//   - Threshold is sampled every cycle and may change mid-check. The comparison
//     is >=, so a lowered Threshold completes on the next agreeing sample.
//   - cnt saturates at 2^CNT_W-1 and never wraps.
//   - Rise and Fall are mutually exclusive per channel and are never asserted in
//     consecutive cycles when N>1.
//   Event flags (per channel), where edge = Rise|Fall
//   - EvtPending next = edge | (EvtPending & ~EvtAck).
//     If edge and EvtAck coincide, EvtPending stays 1: the new event wins.
//   - EvtOverrun next = (edge & EvtPending & ~EvtAck) | (EvtOverrun & ~EvtAck).
//   - An EvtAck while EvtPending=0 has no effect.
//   Channel independence
//   - Channels are fully independent. Simultaneous edges on several channels are
//     all reported in the same cycle.
//
// STRUCTURE
//   Shared package pad_debounce_pkg
//   - state enum: LO=2'b00, CHK_HI=2'b01, HI=2'b11, CHK_LO=2'b10;
//   - default SYNC_STAGES;
//   - helper function eff_thresh(t) returning max(t,1).
//   Sub-module debounce_channel (one instance per channel via generate)
//   - contains the synchroniser, FSM, counter and event flags;
//   - has CNT_W and SYNC_STAGES parameters.
//   Top level
//   - only replicates debounce_channel and fans Threshold out to all channels.
//
// TESTING
//   1. Reset, hold PadIn=0000, then release nReset. Level, Rise, Fall,
//      EvtPending and EvtOverrun stay 0 for 20 cycles.
//   2. Threshold=5, then PadIn[0] rises and stays high.
//      Level[0]=1 exactly 2+5=7 edges later, with Rise[0] high for one cycle and EvtPending[0]=1.
//   3. Threshold=5 and a 4-cycle high glitch on PadIn[1].
//      No Rise[1], no Level change, and EvtPending[1] stays 0.
//   4. Threshold=0 and PadIn[2] toggles 0->1.
//      Level[2] rises 3 edges later, the same as Threshold=1.
//   5. Two edges on ch3 with no acknowledge: EvtOverrun[3]=1.
//      Then EvtAck[3] in the same cycle as a third edge: EvtPending[3]=1 and EvtOverrun[3]=0.
//   6. Threshold=200 with PadIn[0] held high for 50 cycles into a check.
//      Assert nReset low for 1 cycle: the FSM returns to LO, Level stays 0 and no Rise is emitted.

Source files
------------

// File: rtl/pad_debounce_pkg.sv
// Shared types and helpers for the pad input debouncer.
package pad_debounce_pkg;

  typedef enum logic [1:0] {
    LO     = 2'b00,
    CHK_HI = 2'b01,
    HI     = 2'b11,
    CHK_LO = 2'b10
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;

  // A threshold of zero behaves exactly like a threshold of one.
  function automatic int unsigned eff_thresh(input int unsigned t);
    if (t == 32'd0) return 32'd1;
    else return t;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One pad channel: synchroniser, glitch-filter FSM with stability counter,
// edge pulses and sticky event flags.
module debounce_channel
  import pad_debounce_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             PadIn,
  input  logic [CNT_W-1:0] Threshold,
  input  logic             EvtAck,
  output logic             Level,
  output logic             Rise,
  output logic             Fall,
  output logic             EvtPending,
  output logic             EvtOverrun
);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pend;
  logic                   r_ovr;

  logic                   w_s;
  int unsigned            w_n;
  logic                   w_n_one;
  logic                   w_reach;
  logic                   w_rise_go;
  logic                   w_fall_go;
  logic                   w_edge;
  logic [CNT_W-1:0]       w_cnt_sat;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_n       = eff_thresh(32'(Threshold));
  assign w_n_one   = (w_n == 32'd1);
  // Compared with >= so a threshold lowered mid-check completes on the next agreeing sample.
  assign w_reach   = ((32'(r_cnt) + 32'd1) >= w_n);
  assign w_cnt_sat = (&r_cnt) ? r_cnt : (r_cnt + CNT_W'(1));

  assign w_rise_go = w_s & (((r_state == LO) & w_n_one) | ((r_state == CHK_HI) & w_reach));
  assign w_fall_go = ~w_s & (((r_state == HI) & w_n_one) | ((r_state == CHK_LO) & w_reach));
  assign w_edge    = w_rise_go | w_fall_go;

  // Synchroniser, filter FSM, pulses and sticky flags share one registered block.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_sync  <= '0;
      r_state <= LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_pend  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], PadIn};
      r_rise <= w_rise_go;
      r_fall <= w_fall_go;
      r_pend <= w_edge | (r_pend & ~EvtAck);
      r_ovr  <= (w_edge & r_pend & ~EvtAck) | (r_ovr & ~EvtAck);
      case (r_state)
        LO: begin
          if (w_rise_go) begin
            r_state <= HI;
            r_level <= 1'b1;
            r_cnt   <= '0;
          end else if (w_s) begin
            r_state <= CHK_HI;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        CHK_HI: begin
          if (w_rise_go) begin
            r_state <= HI;
            r_level <= 1'b1;
            r_cnt   <= '0;
          end else if (w_s) begin
            r_cnt   <= w_cnt_sat;
          end else begin
            r_state <= LO;
            r_cnt   <= '0;
          end
        end
        HI: begin
          if (w_fall_go) begin
            r_state <= LO;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else if (!w_s) begin
            r_state <= CHK_LO;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_cnt   <= '0;
          end
        end
        CHK_LO: begin
          if (w_fall_go) begin
            r_state <= LO;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else if (!w_s) begin
            r_cnt   <= w_cnt_sat;
          end else begin
            r_state <= HI;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= LO;
          r_level <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Level      = r_level;
  assign Rise       = r_rise;
  assign Fall       = r_fall;
  assign EvtPending = r_pend;
  assign EvtOverrun = r_ovr;

endmodule

// File: rtl/pad_input_debounce.sv
// Pad input conditioner: replicates one debounce channel per pad and shares
// the threshold across all of them.
module pad_input_debounce
  import pad_debounce_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = 8
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [NCH-1:0]   PadIn,
  input  logic [CNT_W-1:0] Threshold,
  output logic [NCH-1:0]   Level,
  output logic [NCH-1:0]   Rise,
  output logic [NCH-1:0]   Fall,
  output logic [NCH-1:0]   EvtPending,
  output logic [NCH-1:0]   EvtOverrun,
  input  logic [NCH-1:0]   EvtAck
);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    debounce_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .Clock      (Clock),
      .nReset     (nReset),
      .PadIn      (PadIn[g]),
      .Threshold  (Threshold),
      .EvtAck     (EvtAck[g]),
      .Level      (Level[g]),
      .Rise       (Rise[g]),
      .Fall       (Fall[g]),
      .EvtPending (EvtPending[g]),
      .EvtOverrun (EvtOverrun[g])
    );
  end

endmodule
